// File: rtl/serial_number_transmitter_with_mod_fsm.sv
// Serial number transmitter: takes a WIDTH-bit number over valid/ready and
// emits it MSB-first with frame markers, alongside the running remainder of
// the transmitted prefix modulo DIVISOR (tracked by a table-driven FSM).
module serial_number_transmitter_with_mod_fsm #(
   parameter int WIDTH   = 8,
   parameter int DIVISOR = 5,
   localparam int RW     = $clog2(DIVISOR)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_bit,
   output logic          out_first,
   output logic          out_last,
   output logic [RW-1:0] out_rem,
   output logic          out_div
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int NR = 1 << RW;

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic [RW-1:0]    rem_q,   rem_d;

   logic in_fire, out_fire;

   // Remainder FSM transition table: (remainder, bit) -> (2*remainder+bit) mod DIVISOR.
   // Entries are elaboration-time constants; codes >= DIVISOR are unreachable.
   logic [RW-1:0] rem_tbl [NR][2];
   for (genvar r = 0; r < NR; r++) begin : g_tbl
      for (genvar b = 0; b < 2; b++) begin : g_bit
         if (r < DIVISOR) begin : g_valid
            assign rem_tbl[r][b] = RW'((2 * r + b) % DIVISOR);
         end else begin : g_pad
            assign rem_tbl[r][b] = '0;
         end
      end
   end

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   // State and datapath registers; reset aborts any frame in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
      end
   end

   // Next state: advance on each consumed bit, reload on an accepted number
   // (which can coincide with the last bit, giving bubble-free frames).
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      if (out_fire) begin
         rem_d   = out_rem;
         shreg_d = shreg_q << 1;
         cnt_d   = cnt_q - CW'(1);
         if (out_last) begin
            state_d = IDLE;
         end
      end
      if (in_fire) begin
         state_d = SEND;
         shreg_d = in_data;
         cnt_d   = CW'(WIDTH - 1);
         rem_d   = '0;
      end
   end

   // Outputs: sideband is only meaningful while sending, forced to 0 otherwise.
   // in_ready looks through out_ready so the next number loads on the last bit.
   always_comb begin
      out_valid = 1'b0;
      out_bit   = 1'b0;
      out_first = 1'b0;
      out_last  = 1'b0;
      out_rem   = '0;
      out_div   = 1'b0;
      if (state_q == SEND) begin
         out_valid = 1'b1;
         out_bit   = shreg_q[WIDTH-1];
         out_first = (cnt_q == CW'(WIDTH - 1));
         out_last  = (cnt_q == '0);
         out_rem   = rem_tbl[rem_q][shreg_q[WIDTH-1]];
         out_div   = (out_rem == '0);
      end
      in_ready = (state_q == IDLE) | (out_valid & out_last & out_ready);
   end

endmodule
